// File: rtl/regfile_access_arbiter_pkg.sv
// regfile_arb_pkg: shared states, requester ids and default sizes for the register file arbiter
package regfile_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_e;
endpackage

// File: rtl/regfile_access_arbiter_decoder.sv
// decoder5to32: binary index to one-hot register enable, all zero when disabled
module decoder5to32 (
  input  logic        en_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] out_o
);
  // shift a single enable bit into the selected position
  always_comb out_o = {31'b0, en_i} << sel_i;
endmodule

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin req/ack sequencer and clear engine in front of the 32x32 register file
module regfile_access_arbiter #(
  parameter int NUM_REGS = regfile_arb_pkg::NUM_REGS,
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W = regfile_arb_pkg::DATA_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear_req,
  output logic                busy,
  input  logic                a_req,
  input  logic                b_req,
  input  logic                a_we,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                a_ack,
  output logic                b_ack,
  output logic [DATA_W-1:0]   a_rdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic [NUM_REGS-1:0] rf_en,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [ADDR_W-1:0]   rf_select,
  input  logic [DATA_W-1:0]   rf_rdata
);
  import regfile_arb_pkg::*;
  state_e state_q, state_d;
  logic last_q, last_d, pend_q, pend_d, gnt_q, gnt_d, we_q, we_d, win_b;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  // state register; reset aborts any in-flight transaction
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= REQ_B;
      pend_q    <= 1'b0;
      gnt_q     <= REQ_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end
  // next state: clear has priority in IDLE, ties go to the requester not served last
  always_comb begin
    win_b     = b_req && (!a_req || last_q == REQ_B ? !a_req : 1'b1);
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    pend_d    = (state_q == IDLE) ? 1'b0 : pend_q | clear_req;
    case (state_q)
      IDLE: begin
        if (clear_req || pend_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (a_req || b_req) begin
          state_d = ACCESS;
          gnt_d   = win_b ? REQ_B : REQ_A;
          last_d  = win_b ? REQ_B : REQ_A;
          we_d    = win_b ? b_we : a_we;
          addr_d  = win_b ? b_addr : a_addr;
          wdata_d = win_b ? b_wdata : a_wdata;
        end
      end
      ACCESS: begin
        state_d   = RESP;
        a_rdata_d = (!we_q && gnt_q == REQ_A) ? rf_rdata : a_rdata_q;
        b_rdata_d = (!we_q && gnt_q == REQ_B) ? rf_rdata : b_rdata_q;
      end
      RESP: state_d = IDLE;
      CLEAR: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == ADDR_W'(NUM_REGS - 1)) ? IDLE : CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end
  decoder5to32 u_dec (
    .en_i  ((state_q == ACCESS && we_q) || state_q == CLEAR),
    .sel_i (state_q == CLEAR ? cnt_q : addr_q),
    .out_o (rf_en)
  );
  assign rf_wdata  = (state_q == ACCESS && we_q) ? wdata_q : '0;
  assign rf_select = addr_q;
  assign busy      = state_q != IDLE;
  assign a_ack     = state_q == RESP && gnt_q == REQ_A;
  assign b_ack     = state_q == RESP && gnt_q == REQ_B;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: directed and random checks of the arbiter against a register file model
module tb_regfile_access_arbiter;
  localparam logic A = 1'b0;
  localparam logic B = 1'b1;
  logic clock = 0, reset_n = 0, clear_req = 0, busy;
  logic a_req = 0, b_req = 0, a_we = 0, b_we = 0, a_ack, b_ack;
  logic [4:0] a_addr = 0, b_addr = 0, rf_select;
  logic [31:0] a_wdata = 0, b_wdata = 0, a_rdata, b_rdata, rf_en, rf_wdata, rf_rdata;
  logic [31:0] rf [32] = '{default: '0};
  logic [31:0] mem [32] = '{default: '0};
  logic [31:0] vals [7];
  int checks = 0, errors = 0;
  logic last_w = B;

  always #5 clock = ~clock;

  always @(posedge clock) for (int i = 0; i < 32; i++) if (rf_en[i]) rf[i] <= rf_wdata;
  assign rf_rdata = rf[rf_select];

  regfile_access_arbiter dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .rf_en(rf_en), .rf_wdata(rf_wdata), .rf_select(rf_select), .rf_rdata(rf_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic setup(input logic who, input logic we, input logic [4:0] ad, input logic [31:0] d);
    if (who == A) begin a_req = 1; a_we = we; a_addr = ad; a_wdata = d; end
    else begin b_req = 1; b_we = we; b_addr = ad; b_wdata = d; end
  endtask

  task automatic finish_op(input logic who, input logic we, input logic [4:0] ad, input logic [31:0] d);
    if (we) mem[ad] = d;
    else chk(who ? "b_rdata" : "a_rdata", who ? b_rdata : a_rdata, mem[ad]);
    if (who == A) a_req = 0; else b_req = 0;
  endtask

  // one round from IDLE: single requester acks at cycle 2, a tie serves both at cycles 2 and 5
  task automatic round(input logic ua, input logic ub, input logic wa, input logic wb,
                       input logic [4:0] aa, input logic [4:0] ab, input logic [31:0] da, input logic [31:0] db);
    logic first;
    int ta, tb;
    first = (ua && ub) ? ~last_w : ub;
    ta = !ua ? -1 : (first == A ? 2 : 5);
    tb = !ub ? -1 : (first == B ? 2 : 5);
    if (ua) setup(A, wa, aa, da);
    if (ub) setup(B, wb, ab, db);
    for (int c = 1; c <= 6; c++) begin
      tick;
      chk("a_ack", a_ack, c == ta);
      chk("b_ack", b_ack, c == tb);
      chk("busy", busy, c == 1 || c == 2 || (ua && ub && (c == 4 || c == 5)));
      if (c == ta) finish_op(A, wa, aa, da);
      if (c == tb) finish_op(B, wb, ab, db);
    end
    last_w = (ua && ub) ? ~first : first;
  endtask

  task automatic sweep_from(input int k0);
    for (int k = k0; k < 32; k++) begin
      chk("clr_busy", busy, 1);
      chk("clr_en", rf_en, 32'(1) << k);
      chk("clr_wdata", rf_wdata, 0);
      tick;
    end
    for (int i = 0; i < 32; i++) mem[i] = 0;
  endtask

  initial begin
    #2;
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", rf_en, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_sel", rf_select, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    tick;
    reset_n = 1;
    tick;
    round(1, 1, 1, 1, 0, 1, 32'h1, 32'h2);
    round(1, 0, 1, 0, 5, 0, 32'h0000_F000, 0);
    round(1, 0, 0, 0, 5, 0, 0, 0);
    chk("wr_rd_r5", a_rdata, 32'h0000_F000);
    begin
      logic w, win;
      w = ~last_w;
      a_req = 1; b_req = 1; a_we = 1; b_we = 1;
      a_addr = 1; a_wdata = 32'hA; b_addr = 2; b_wdata = 32'hB;
      for (int c = 1; c <= 11; c++) begin
        tick;
        win = w ^ 1'(((c - 2) / 3) & 1);
        chk("tie_a_ack", a_ack, (c % 3 == 2) && win == A);
        chk("tie_b_ack", b_ack, (c % 3 == 2) && win == B);
      end
      a_req = 0; b_req = 0;
      mem[1] = 32'hA; mem[2] = 32'hB;
      last_w = ~w;
      tick;
    end
    round(1, 1, 0, 0, 1, 2, 0, 0);
    vals = '{32'd15, 32'd10, 32'd0, 32'd1, 32'd2, 32'h0000_F000, 32'd4};
    for (int i = 0; i < 7; i++) round(1, 0, 1, 0, 5'(i), 0, vals[i], 0);
    clear_req = 1;
    tick;
    clear_req = 0;
    sweep_from(0);
    chk("clr_done_busy", busy, 0);
    chk("clr_done_en", rf_en, 0);
    for (int i = 0; i < 7; i++) round(1, 0, 0, 0, 5'(i), 0, 0, 0);
    round(0, 1, 0, 1, 0, 3, 0, 32'd1);
    setup(B, 0, 3, 0);
    tick;
    clear_req = 1;
    tick;
    clear_req = 0;
    chk("cda_b_ack", b_ack, 1);
    chk("cda_b_rdata", b_rdata, 1);
    b_req = 0;
    last_w = B;
    tick;
    chk("cda_idle", busy, 0);
    tick;
    sweep_from(0);
    chk("cda_done", busy, 0);
    round(1, 0, 1, 0, 7, 0, 32'h33, 0);
    setup(A, 1, 7, 32'h55);
    tick;
    chk("mid_en", rf_en, 32'(1) << 7);
    reset_n = 0;
    #1;
    chk("mid_rst_en", rf_en, 0);
    chk("mid_rst_ack", a_ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_b_rdata", b_rdata, 0);
    a_req = 0;
    tick;
    chk("mid_r7", rf[7], mem[7]);
    reset_n = 1;
    last_w = B;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("mid_no_ack", a_ack, 0);
    end
    round(1, 1, 0, 0, 7, 7, 0, 0);
    for (int n = 0; n < 30; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      round(m[0], m[1], 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
